ram16k_reader: RTL
==================

Name: ram16k_reader

Overview:
- Read-side master for the RAM16K memory port. Drives `address`, holds `load` low, and samples the RAM's `out` word.
- Streams a contiguous block of words, starting at a given base address, onto a valid/ready output with a last-word flag.
- Sits between the RAM16K instance and any consumer, such as a screen refresher, serial dumper or checker. It is the reading counterpart to benches and CPUs that write the RAM.

Parameters:
- ADDR_W, 14, memory address width (16K words).
- DATA_W, 16, memory word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base  input  ADDR_W  first word address, latched on accepted start.
- length  input  ADDR_W+1  number of words, 0..16384, latched on accepted start.
- busy  output  1  high from accepted start until done pulse (inclusive).
- done  output  1  one-cycle pulse at end of transfer.
- mem_address  output  ADDR_W  address to RAM16K.
- mem_load  output  1  RAM16K write enable; constant 0.
- mem_out  input  DATA_W  RAM16K read data; asynchronous read of mem_address.
- m_data  output  DATA_W  stream word.
- m_valid  output  1  stream word valid.
- m_ready  input  1  consumer ready.
- m_last  output  1  high with m_valid on the final word.

Behaviour:
- Reset (clk edge with reset=1) forces IDLE. Register reset values:
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_address=0.
  - internal addr=0, remaining=0.
- Reset dominates all other inputs. Reset mid-transfer abandons it: no done pulse, and m_valid=0 from the next cycle.
- States are IDLE, FETCH, PRESENT and FINISH.
- IDLE:
  - start=1 with length!=0: latch addr=base and remaining=length, drive mem_address=base, go to FETCH. busy=1 from the next cycle.
  - start=1 with length=0: go to FINISH directly; no word is streamed.
- FETCH (1 cycle):
  - mem_address holds addr all cycle.
  - At the edge, m_data <= mem_out, m_valid <= 1, and m_last <= (remaining==1). Go to PRESENT.
- PRESENT:
  - m_valid=1; m_data and m_last are held stable while m_ready=0.
  - On handshake (m_valid & m_ready at an edge) with remaining==1: m_valid <= 0, m_last <= 0, go to FINISH.
  - On handshake otherwise: addr <= (addr+1) mod 2^ADDR_W (16383 wraps to 0), remaining <= remaining-1, mem_address <= next addr, m_valid <= 0, go to FETCH.
- FINISH: done=1 and busy=1 for exactly one cycle, then IDLE.
- Throughput: one word per 2 cycles minimum.
  - First m_valid appears 2 cycles after the start edge.
  - done rises the cycle after the final handshake.
- start while busy is ignored, with no effect on the latched parameters.
- base/length changes after start is accepted have no effect.
- mem_load is never asserted. The block never writes memory.

Optional Feature:
- Macro RAM16K_READER_CHECKSUM_EN.
- Defined:
  - Adds output port `checksum` (DATA_W).
  - checksum clears to 0 on reset and on each accepted start.
  - On every handshake, checksum <= checksum + m_data (mod 2^DATA_W).
  - The value is final and stable when done=1, and held until the next start.
- Undefined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- Shared include memory_defs.vh holds:
  - MEM_ADDR_W=14, MEM_DATA_W=16, MEM_WORDS=16384.
  - State encodings: S_IDLE=2'd0, S_FETCH=2'd1, S_PRESENT=2'd2, S_FINISH=2'd3.
- Single module; no sub-module needed. The address counter, remaining counter and output register are small enough to stay inline.

Test Plan:
1. Reset held 2 cycles while start=1 -> busy, done, m_valid, m_last and mem_load are 0, mem_address=0, and no transfer begins.
2. Bench preloads RAM[0..4]=0x1000..0x1004, then start base=0 len=5 with m_ready=1 -> m_data 1000,1001,1002,1003,1004 (one per 2 cycles), m_last only with 1004, done pulse 1 cycle after the last handshake, busy low after it.
3. Same preload, len=5, m_ready low for 3 cycles during word 0x1002 -> m_data=1002 held for the whole stall, no word duplicated or skipped, checksum=0x500A (with macro).
4. Preload RAM[16382]=A, RAM[16383]=B, RAM[0]=C, RAM[1]=D; start base=16382 len=4 -> mem_address sequence 16382,16383,0,1 and stream A,B,C,D.
5. start len=0 -> no m_valid; busy and done high together for one cycle, 1 cycle after start. A second start pulsed during a len=3 transfer -> ignored, exactly 3 words out.
6. reset asserted while in PRESENT on word 2 of 5 -> m_valid=0 and busy=0 the next cycle, no done pulse; a fresh start afterwards streams correctly from its new base.

Source files
------------

// File: rtl/ram16k_reader_pkg.sv
// Shared memory geometry and FSM state encoding for the RAM16K read-side master.
package ram16k_reader_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_WORDS  = 16384;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

endpackage

// File: rtl/ram16k_reader.sv
// RAM16K read-side master: streams a contiguous block of words from base onto a
// valid/ready output with a last-word flag, pulsing done at the end.
// Optional running checksum of handed-off words: define RAM16K_READER_CHECKSUM_EN.
module ram16k_reader
  import ram16k_reader_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef RAM16K_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              handshake;
  logic              final_word;

  assign handshake   = m_valid && m_ready;
  assign final_word  = (remaining == (ADDR_W+1)'(1));
  assign mem_address = addr;
  assign mem_load    = 1'b0;

  // State register; reset abandons any transfer in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus busy/done, which follow directly from the state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? S_FINISH : S_FETCH;
        end
      end
      S_FETCH: begin
        busy       = 1'b1;
        state_next = S_PRESENT;
      end
      S_PRESENT: begin
        busy = 1'b1;
        if (handshake) begin
          state_next = final_word ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Address/remaining counters and the stream output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            addr      <= base;
            remaining <= length;
          end
        end
        S_FETCH: begin
          m_data  <= mem_out;
          m_valid <= 1'b1;
          m_last  <= final_word;
        end
        S_PRESENT: begin
          if (handshake) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (!final_word) begin
              addr      <= addr + ADDR_W'(1);
              remaining <= remaining - (ADDR_W+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM16K_READER_CHECKSUM_EN
  // Running sum of every word accepted by the consumer; cleared on each new start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      checksum <= '0;
    end else if ((state == S_PRESENT) && handshake) begin
      checksum <= checksum + m_data;
    end
  end
`endif

endmodule
